// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scheduler.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCH   = 2'd1,
    CONVERT = 2'd2,
    SHOW    = 2'd3
  } state_e;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'h3F;
  localparam logic [31:0] MAX_DISP  = 32'd99_999_999;

  // Active-low gfedcba codes; BCD values 10..15 never appear on a lit digit.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [2:0] pick_hi(input logic [2:0] r);
    if (r[2]) return 3'b100;
    if (r[1]) return 3'b010;
    if (r[0]) return 3'b001;
    return 3'b000;
  endfunction

endpackage

// File: rtl/disp_share_sched_if.sv
// Requester/display bundle between game logic and the display scheduler.
interface disp_share_sched_if;
  logic [2:0]  req;
  logic [31:0] value0;
  logic [31:0] value1;
  logic [31:0] value2;
  logic [2:0]  gnt;
  logic        busy;
  logic [6:0]  oData;
  logic [7:0]  law;

  modport master (
    output req, value0, value1, value2,
    input  gnt, busy, oData, law
  );

  modport slave (
    input  req, value0, value1, value2,
    output gnt, busy, oData, law
  );
endinterface

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble: 32-bit binary to 8-digit BCD, one step per clock.
// bcd_o is the result of the current step and is valid while done_o is high.
module bcd_seq_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] bcd_o
);

  logic [31:0] bin_q, bin_d;
  logic [31:0] bcd_q, bcd_d;
  logic [4:0]  step_q, step_d;
  logic        busy_q, busy_d;
  logic [31:0] adj;

  // NOTE: every _d gets a default before any branch so this block never infers a latch.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    step_d = step_q;
    busy_d = busy_q;
    for (int i = 0; i < 8; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bcd_o  = 32'({adj, bin_q[31]});
    done_o = busy_q && (step_q == 5'd31);

    if (busy_q) begin
      bin_d  = {bin_q[30:0], 1'b0};
      bcd_d  = bcd_o;
      step_d = step_q + 5'd1;
      if (done_o) busy_d = 1'b0;
    end else if (start) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      step_d = '0;
      busy_d = 1'b1;
    end
  end

  // NOTE: flops use <= so each one samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      step_q <= step_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/disp_share_sched.sv
// Shares one 8-digit multiplexed display between three prioritised requesters;
// the winner's value is converted to BCD and scanned out while a double buffer holds the old digits.
module disp_share_sched
  import disp_pkg::*;
#(
  parameter int HOLD_TICKS    = 2000,
  parameter int REFRESH_TICKS = 100,
  parameter bit LZ_BLANK      = 1'b1
) (
  input logic               clk_1000,
  input logic               rst,
  disp_share_sched_if.slave bus
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_MAX     = HW'(HOLD_TICKS);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_TICKS - 1);

  state_e        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          ovf_q, ovf_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [31:0]   disp_q, disp_d;
  logic          disp_ovf_q, disp_ovf_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    law_q, law_d;

  logic [31:0] sel_value;
  logic [31:0] conv_bcd;
  logic        conv_start, conv_busy, conv_done;
  logic [2:0]  req_hi;
  logic        rearb;
  logic [7:0]  lit;
  logic [3:0]  nib;

  assign req_hi = pick_hi(bus.req);

  always_comb begin
    sel_value = '0;
    case (gnt_q)
      3'b001:  sel_value = bus.value0;
      3'b010:  sel_value = bus.value1;
      3'b100:  sel_value = bus.value2;
      default: sel_value = '0;
    endcase
  end

  bcd_seq_conv u_conv (
    .clk    (clk_1000),
    .rst    (rst),
    .start  (conv_start),
    .bin_i  (sel_value),
    .busy_o (conv_busy),
    .done_o (conv_done),
    .bcd_o  (conv_bcd)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ovf_d      = ovf_q;
    hold_d     = hold_q;
    refresh_d  = refresh_q;
    disp_d     = disp_q;
    disp_ovf_d = disp_ovf_q;
    conv_start = 1'b0;
    rearb      = 1'b0;

    // The hold counts every cycle the grant is owned, not just SHOW cycles.
    if (state_q != IDLE && hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;

    case (state_q)
      IDLE: begin
        hold_d    = '0;
        refresh_d = '0;
        if (bus.req != 3'b000) begin
          gnt_d   = req_hi;
          state_d = LATCH;
        end
      end
      LATCH: begin
        conv_start = 1'b1;
        ovf_d      = (sel_value > MAX_DISP);
        state_d    = CONVERT;
      end
      CONVERT: begin
        if (conv_done) begin
          disp_d     = conv_bcd;
          disp_ovf_d = ovf_q;
          state_d    = SHOW;
        end
      end
      SHOW: begin
        if (refresh_q == REFRESH_LAST) begin
          refresh_d = '0;
          state_d   = LATCH;
          // A dropped request wins over the hold; a higher one waits for it.
          rearb = ((bus.req & gnt_q) == 3'b000) ||
                  ((hold_q == HOLD_MAX) && (req_hi > gnt_q));
          if (rearb) begin
            gnt_d = req_hi;
            if (req_hi != gnt_q) hold_d = '0;
            if (bus.req == 3'b000) state_d = IDLE;
          end
        end else begin
          refresh_d = refresh_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit i is lit when it or any digit above it is nonzero; digit 0 always is.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lit[i] = (i == 0) || ((disp_q >> (4 * i)) != 32'd0);
    end
  end

  always_comb begin
    idx_d = idx_q;
    law_d = 8'hFF;
    seg_d = SEG_BLANK;
    nib   = disp_q[{idx_q, 2'b00} +: 4];
    if (state_q != IDLE) begin
      idx_d = idx_q + 3'd1;
      law_d = ~(8'b1 << idx_q);
      if (disp_ovf_q)                 seg_d = SEG_DASH;
      else if (!LZ_BLANK || lit[idx_q]) seg_d = seg_of(nib);
    end
  end

  always_ff @(posedge clk_1000) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ovf_q      <= 1'b0;
      hold_q     <= '0;
      refresh_q  <= '0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      law_q      <= 8'hFF;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ovf_q      <= ovf_d;
      hold_q     <= hold_d;
      refresh_q  <= refresh_d;
      disp_q     <= disp_d;
      disp_ovf_q <= disp_ovf_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      law_q      <= law_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.busy  = conv_busy;
  assign bus.oData = seg_q;
  assign bus.law   = law_q;

endmodule

// File: tb/tb_disp_share_sched.sv
// Scoreboard bench for disp_share_sched: expected 8-digit patterns are queued
// when a value is requested and compared against one full captured scan.
module tb_disp_share_sched;

  localparam int HOLD_TICKS    = 2000;
  localparam int REFRESH_TICKS = 100;

  logic clk_1000 = 1'b0;
  logic rst      = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic [55:0] exp_q[$];

  disp_share_sched_if bus();

  disp_share_sched #(
    .HOLD_TICKS    (HOLD_TICKS),
    .REFRESH_TICKS (REFRESH_TICKS),
    .LZ_BLANK      (1'b1)
  ) dut (
    .clk_1000 (clk_1000),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_1000 = ~clk_1000;
  always @(posedge clk_1000) cyc <= cyc + 1;

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments for digits 0..7, packed with digit i at bits [7i +: 7].
  function automatic logic [55:0] model(input logic [31:0] v);
    logic [55:0] r;
    logic [31:0] t;
    int d[8];
    int msd;
    if (v > 32'd99_999_999) return {8{7'b0111111}};
    t = v;
    msd = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = int'(t % 32'd10);
      t = t / 32'd10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < 8; i++) r[7*i +: 7] = (i <= msd) ? seg7(d[i]) : 7'b1111111;
    return r;
  endfunction

  task automatic capture_scan(output logic [55:0] got, output bit hot);
    logic [7:0] seen;
    seen = '0;
    got  = '1;
    hot  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_1000);
      if ($countones(~bus.law) != 1) hot = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (bus.law == ~(8'b1 << i)) begin
          got[7*i +: 7] = bus.oData;
          seen[i] = 1'b1;
        end
      end
    end
    if (seen != 8'hFF) hot = 1'b0;
  endtask

  task automatic wait_busy_fall(input int budget, output int t, output bit ok);
    bit prev, rose;
    prev = 1'b0;
    rose = 1'b0;
    ok   = 1'b0;
    t    = 0;
    while (t < budget && !ok) begin
      @(negedge clk_1000);
      t++;
      if (!prev && bus.busy) rose = 1'b1;
      else if (rose && !bus.busy) ok = 1'b1;
      prev = bus.busy;
    end
  endtask

  task automatic go_idle(output bit ok);
    bus.req = 3'b000;
    ok = 1'b0;
    for (int i = 0; i < REFRESH_TICKS + 60 && !ok; i++) begin
      @(negedge clk_1000);
      if (bus.gnt == 3'b000) ok = 1'b1;
    end
    @(negedge clk_1000);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 3'b000;
    bus.value0 = '0;
    bus.value1 = '0;
    bus.value2 = '0;
    repeat (2) @(negedge clk_1000);
    n_checks++; if (bus.gnt !== 3'b000) $display("FAIL reset_gnt: got %b want 000", bus.gnt); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.law !== 8'hFF) $display("FAIL reset_law: got %h want ff", bus.law); else n_pass++;
    n_checks++; if (bus.oData !== 7'h7F) $display("FAIL reset_odata: got %h want 7f", bus.oData); else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk_1000);
    n_checks++; if (bus.law !== 8'hFF) $display("FAIL idle_law: got %h want ff", bus.law); else n_pass++;
  endtask

  task automatic test_basic();
    int busy_cnt, fall_k;
    logic [55:0] got, exp;
    bit hot;
    bus.value0 = 32'd1234;
    bus.req = 3'b001;
    exp_q.push_back(model(32'd1234));
    @(negedge clk_1000);
    n_checks++; if (bus.gnt !== 3'b001) $display("FAIL basic_gnt: got %b want 001", bus.gnt); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_latch: got %b want 0", bus.busy); else n_pass++;
    busy_cnt = 0;
    fall_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_1000);
      if (bus.busy === 1'b1) busy_cnt++;
      else if (busy_cnt > 0 && fall_k < 0) fall_k = k;
    end
    n_checks++; if (busy_cnt != 32) $display("FAIL basic_busy_len: got %0d want 32", busy_cnt); else n_pass++;
    n_checks++; if (fall_k != 33) $display("FAIL basic_latency: got %0d want 33", fall_k); else n_pass++;
    capture_scan(got, hot);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL basic_digits: got %h want %h", got, exp); else n_pass++;
    n_checks++; if (!hot) $display("FAIL basic_scan_onehot: got 0 want 1"); else n_pass++;
  endtask

  task automatic test_drop_to_idle();
    int t;
    bit ok;
    bus.req = 3'b000;
    ok = 1'b0;
    t = 0;
    while (t < REFRESH_TICKS + 38 && !ok) begin
      @(negedge clk_1000);
      t++;
      if (bus.gnt == 3'b000) ok = 1'b1;
    end
    n_checks++; if (!ok) $display("FAIL drop_gnt_timeout: got gnt %b after %0d cycles want 000", bus.gnt, t); else n_pass++;
    @(negedge clk_1000);
    n_checks++; if (bus.law !== 8'hFF) $display("FAIL drop_law: got %h want ff", bus.law); else n_pass++;
    n_checks++; if (bus.oData !== 7'h7F) $display("FAIL drop_odata: got %h want 7f", bus.oData); else n_pass++;
  endtask

  task automatic test_overflow();
    int t;
    bit ok, hot;
    logic [55:0] got, exp;
    bus.value1 = 32'd100_000_000;
    bus.req = 3'b010;
    exp_q.push_back(model(32'd100_000_000));
    wait_busy_fall(60, t, ok);
    n_checks++; if (!ok) $display("FAIL ovf_timeout: got %0d cycles want done", t); else n_pass++;
    n_checks++; if (bus.gnt !== 3'b010) $display("FAIL ovf_gnt: got %b want 010", bus.gnt); else n_pass++;
    capture_scan(got, hot);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp || !hot) $display("FAIL ovf_digits: got %h want %h", got, exp); else n_pass++;
    go_idle(ok);
    n_checks++; if (!ok) $display("FAIL ovf_idle: got gnt %b want 000", bus.gnt); else n_pass++;
  endtask

  task automatic test_values();
    logic [31:0] vals[5];
    logic [55:0] got, exp;
    int t;
    bit ok, hot;
    vals = '{32'd0, 32'd7, 32'd10, 32'd99_999_999, 32'd3_000_000};
    foreach (vals[n]) begin
      bus.value0 = vals[n];
      bus.req = 3'b001;
      exp_q.push_back(model(vals[n]));
      wait_busy_fall(60, t, ok);
      capture_scan(got, hot);
      exp = exp_q.pop_front();
      n_checks++; if (!ok || got !== exp || !hot) $display("FAIL value_%0d: got %h want %h", vals[n], got, exp); else n_pass++;
      go_idle(ok);
      n_checks++; if (!ok) $display("FAIL value_idle_%0d: got gnt %b want 000", vals[n], bus.gnt); else n_pass++;
    end
  endtask

  task automatic test_hold_preempt();
    int g0, sw_k, t;
    bit ok, hot, early;
    logic [55:0] got, exp;
    bus.value0 = 32'd42;
    bus.value2 = 32'd7;
    bus.req = 3'b001;
    exp_q.push_back(model(32'd42));
    @(negedge clk_1000);
    g0 = cyc;
    wait_busy_fall(60, t, ok);
    capture_scan(got, hot);
    exp = exp_q.pop_front();
    n_checks++; if (!ok || got !== exp || !hot) $display("FAIL hold_first_digits: got %h want %h", got, exp); else n_pass++;
    while (cyc - g0 < 500) @(negedge clk_1000);
    bus.req = 3'b101;
    exp_q.push_back(model(32'd7));
    early = 1'b0;
    sw_k = -1;
    while (sw_k < 0 && cyc - g0 <= HOLD_TICKS + REFRESH_TICKS + 40) begin
      @(negedge clk_1000);
      if (bus.gnt !== 3'b001) begin
        sw_k = cyc - g0;
        if (sw_k <= HOLD_TICKS) early = 1'b1;
      end
    end
    n_checks++; if (early) $display("FAIL hold_early_switch: got switch at %0d want > %0d", sw_k, HOLD_TICKS); else n_pass++;
    n_checks++; if (sw_k <= HOLD_TICKS || sw_k > HOLD_TICKS + REFRESH_TICKS + 35)
      $display("FAIL hold_switch_point: got %0d want in (%0d,%0d]", sw_k, HOLD_TICKS, HOLD_TICKS + REFRESH_TICKS + 35); else n_pass++;
    n_checks++; if (bus.gnt !== 3'b100) $display("FAIL hold_new_gnt: got %b want 100", bus.gnt); else n_pass++;
    wait_busy_fall(60, t, ok);
    capture_scan(got, hot);
    exp = exp_q.pop_front();
    n_checks++; if (!ok || got !== exp || !hot) $display("FAIL hold_new_digits: got %h want %h", got, exp); else n_pass++;
    go_idle(ok);
    n_checks++; if (!ok) $display("FAIL hold_idle: got gnt %b want 000", bus.gnt); else n_pass++;
  endtask

  task automatic test_ramp();
    int t, t_upd, bad_law, blank0;
    bit ok, hot, prev, rose, upd;
    logic [55:0] got, exp;
    bus.value0 = 32'd998;
    bus.req = 3'b001;
    exp_q.push_back(model(32'd998));
    wait_busy_fall(60, t, ok);
    capture_scan(got, hot);
    exp = exp_q.pop_front();
    n_checks++; if (!ok || got !== exp || !hot) $display("FAIL ramp_start: got %h want %h", got, exp); else n_pass++;
    for (int s = 1; s <= 3; s++) begin
      bus.value0 = 32'd998 + 32'(s);
      exp_q.push_back(model(bus.value0));
      t = 0; t_upd = 0; bad_law = 0; blank0 = 0;
      prev = bus.busy; rose = 1'b0; upd = 1'b0; got = '1;
      while (t < 1000) begin
        @(negedge clk_1000);
        t++;
        if ($countones(~bus.law) != 1) bad_law++;
        if (bus.law == 8'hFE && bus.oData == 7'h7F) blank0++;
        if (!upd) begin
          if (!prev && bus.busy) rose = 1'b1;
          else if (rose && !bus.busy) begin upd = 1'b1; t_upd = t; end
          prev = bus.busy;
        end else if (t <= t_upd + 8) begin
          for (int i = 0; i < 8; i++)
            if (bus.law == ~(8'b1 << i)) got[7*i +: 7] = bus.oData;
          if (t == t_upd + 8) begin
            exp = exp_q.pop_front();
            n_checks++; if (got !== exp) $display("FAIL ramp_digits_%0d: got %h want %h", s, got, exp); else n_pass++;
          end
        end
      end
      n_checks++; if (!upd || t_upd > REFRESH_TICKS + 68) $display("FAIL ramp_update_%0d: got %0d cycles want <= %0d", s, t_upd, REFRESH_TICKS + 68); else n_pass++;
      n_checks++; if (bad_law != 0) $display("FAIL ramp_onehot_%0d: got %0d bad cycles want 0", s, bad_law); else n_pass++;
      n_checks++; if (blank0 != 0) $display("FAIL ramp_blank_%0d: got %0d blank cycles want 0", s, blank0); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_convert();
    int t, bad;
    bit ok, hot;
    logic [55:0] got, exp;
    go_idle(ok);
    bus.value0 = 32'd555;
    bus.req = 3'b001;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk_1000);
      if (bus.busy) ok = 1'b1;
    end
    n_checks++; if (!ok) $display("FAIL rstmid_start: got busy %b want 1", bus.busy); else n_pass++;
    repeat (10) @(negedge clk_1000);
    rst = 1'b1;
    bus.req = 3'b000;
    @(negedge clk_1000);
    rst = 1'b0;
    n_checks++; if (bus.gnt !== 3'b000 || bus.busy !== 1'b0)
      $display("FAIL rstmid_ctrl: got gnt %b busy %b want 000 0", bus.gnt, bus.busy); else n_pass++;
    n_checks++; if (bus.law !== 8'hFF || bus.oData !== 7'h7F)
      $display("FAIL rstmid_blank: got law %h odata %h want ff 7f", bus.law, bus.oData); else n_pass++;
    bad = 0;
    repeat (40) begin
      @(negedge clk_1000);
      if (bus.law !== 8'hFF || bus.gnt !== 3'b000) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL rstmid_quiet: got %0d lit cycles want 0", bad); else n_pass++;
    // The digits shown while the next conversion runs reveal the buffer contents.
    bus.value0 = 32'd77;
    bus.req = 3'b001;
    exp_q.push_back(model(32'd0));
    repeat (2) @(negedge clk_1000);
    capture_scan(got, hot);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp || !hot) $display("FAIL rstmid_old_buffer: got %h want %h", got, exp); else n_pass++;
    exp_q.push_back(model(32'd77));
    wait_busy_fall(60, t, ok);
    capture_scan(got, hot);
    exp = exp_q.pop_front();
    n_checks++; if (!ok || got !== exp || !hot) $display("FAIL rstmid_new_digits: got %h want %h", got, exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop_to_idle();
    test_overflow();
    test_values();
    test_hold_preempt();
    test_ramp();
    test_reset_mid_convert();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
